radix4_mul_scheduler: RTL and testbench

- Round-robin scheduler that shares one radix_4 sequential Booth multiplier among N_REQ requesters.
- Per job: arbitrates, latches the winner's operands, clears the multiplier and pulses its start, then waits for ready.
- Returns the 16-bit product to the winner with a one-cycle done pulse, and flags a timeout if the multiplier never finishes.
- Sits between client blocks and the single radix_4 instance; it is the only driver of the multiplier's inputs.

---
 rtl/radix4_mul_scheduler.sv | 152 +++++++++++++++
 tb/tb_radix4_mul_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_mul_scheduler.sv
// Round-robin front end for a single shared radix-4 sequential multiplier.
// Each job runs IDLE -> ARB -> CLR -> LOAD -> WAIT -> DONE -> IDLE. The
// operands are frozen when the job is arbitrated, the multiplier is cleared
// and started, and the product goes back to the owner with a one-cycle done.
// If the multiplier never raises ready, the job is aborted after TIMEOUT
// WAIT cycles and returns result=0 with err set.
module radix4_mul_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] x_in,
  input  logic [8*N_REQ-1:0] y_in,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [15:0]        result,
  output logic               err,
  output logic               busy,
  output logic               mul_reset,
  output logic               mul_start,
  output logic [7:0]         mul_x,
  output logic [7:0]         mul_y,
  input  logic [15:0]        mul_product,
  input  logic               mul_ready
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_CLR, S_LOAD, S_WAIT, S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic [15:0]      r_result;
  logic             r_err;
  logic             r_mul_reset;
  logic             r_mul_start;
  logic [7:0]       r_mul_x;
  logic [7:0]       r_mul_y;
  logic [7:0]       r_cnt;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic             w_timeout;

  // Rotating priority search: first set req after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_onehot  = N_REQ'(1) << w_win;
  // Fires on the TIMEOUT-th WAIT cycle (counter is zero on the first one).
  assign w_timeout = (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT));

  // Job sequencer; every output toggles on the edge that enters its state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= PW'(N_REQ - 1);
      r_grant     <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_mul_reset <= 1'b1;
      r_mul_start <= 1'b0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mul_reset <= 1'b0;
          if (|req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_grant     <= w_onehot;
            r_rr_ptr    <= w_win;
            r_mul_x     <= x_in[{w_win, 3'b000} +: 8];
            r_mul_y     <= y_in[{w_win, 3'b000} +: 8];
            r_mul_reset <= 1'b1;
            r_state     <= S_CLR;
          end else begin
            // Requester withdrew between IDLE and ARB.
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        S_CLR: begin
          r_mul_reset <= 1'b0;
          r_mul_start <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          r_mul_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // Ready has priority over a coincident timeout.
          if (mul_ready) begin
            r_result <= mul_product;
            r_err    <= 1'b0;
            r_done   <= r_grant;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= r_grant;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_done  <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign result    = r_result;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);
  assign mul_reset = r_mul_reset;
  assign mul_start = r_mul_start;
  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;

endmodule

// File: tb/tb_radix4_mul_scheduler.sv
// Bench for radix4_mul_scheduler: an accumulating multiplier stub, a job-level
// reference model checked every cycle, and directed jobs with literal results.
module tb_radix4_mul_scheduler;
  localparam int N  = 4;
  localparam int TO = 63;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [8*N-1:0] x_in, y_in;
  logic [N-1:0] grant, done;
  logic [15:0]  result;
  logic         err, busy, mul_reset, mul_start;
  logic [7:0]   mul_x, mul_y;
  logic [15:0]  mul_product;
  logic         mul_ready;

  radix4_mul_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .mul_reset(mul_reset), .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clock = ~clock;

  // Multiplier stub: 4 busy cycles, then ready. The product accumulates
  // across jobs unless cleared, so a missing CLR shows up as a wrong sum.
  logic [15:0] s_prod = '0;
  logic        s_rdy  = 1'b0, s_run = 1'b0;
  logic [2:0]  s_cnt  = '0;
  logic [7:0]  s_x = '0, s_y = '0;
  bit          stall  = 1'b0;

  always @(posedge clock) begin
    if (mul_reset) begin
      s_prod <= '0; s_rdy <= 1'b0; s_run <= 1'b0; s_cnt <= '0;
    end else if (mul_start) begin
      s_run <= 1'b1; s_cnt <= '0; s_rdy <= 1'b0; s_x <= mul_x; s_y <= mul_y;
    end else if (s_run) begin
      if (s_cnt == 3'd3) begin
        s_prod <= s_prod + 16'(s_x) * 16'(s_y);
        s_rdy  <= 1'b1;
        s_run  <= 1'b0;
      end else s_cnt <= s_cnt + 3'd1;
    end
  end
  assign mul_product = s_prod;
  assign mul_ready   = s_rdy & ~stall;

  int checks = 0, fails = 0;
  int log_owner[$], log_res[$], log_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [N-1:0]   p_req = '0, p_grant = '0;
  logic [8*N-1:0] p_x = '0, p_y = '0;
  bit             m_act = 1'b0, m_err;
  int             m_age, m_exp, m_ptr = N - 1, m_w, m_idx;
  logic [7:0]     m_x, m_y;
  logic [15:0]    m_res, m_held = '0;
  logic [N-1:0]   m_oh;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mul_reset", 32'(mul_reset), 1);
      m_act = 1'b0; m_ptr = N - 1; m_held = '0;
    end else begin
      if (done != 0) begin
        for (int i = 0; i < N; i++) if (done[i]) log_owner.push_back(i);
        log_res.push_back(int'(result));
        log_err.push_back(int'(err));
      end
      if (grant != 0 && p_grant == 0) begin
        chk("new_job_while_active", 32'(m_act), 0);
        m_w = -1;
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (m_w < 0 && p_req[m_idx]) m_w = m_idx;
        end
        if (m_w < 0) begin
          chk("spurious_grant", 32'(grant), 0);
          m_act = 1'b0;
        end else begin
          m_act = 1'b1; m_age = 0; m_ptr = m_w;
          m_x   = p_x[8*m_w +: 8];
          m_y   = p_y[8*m_w +: 8];
          m_exp = 2 + (stall ? TO : 5);
          m_res = stall ? 16'd0 : 16'(m_x) * 16'(m_y);
          m_err = stall;
        end
      end
      if (m_act) begin
        m_oh = N'(1) << m_w;
        if (m_age <= m_exp) begin
          chk("grant", 32'(grant), 32'(m_oh));
          chk("mul_x", 32'(mul_x), 32'(m_x));
          chk("mul_y", 32'(mul_y), 32'(m_y));
          chk("busy", 32'(busy), 1);
          chk("mul_reset", 32'(mul_reset), (m_age == 0) ? 1 : 0);
          chk("mul_start", 32'(mul_start), (m_age == 1) ? 1 : 0);
          chk("done", 32'(done), (m_age == m_exp) ? 32'(m_oh) : 0);
          if (m_age == m_exp) begin
            chk("result", 32'(result), 32'(m_res));
            chk("err", 32'(err), 32'(m_err));
            m_held = m_res;
          end else chk("result_held", 32'(result), 32'(m_held));
        end else begin
          chk("grant_after_done", 32'(grant), 0);
          chk("done_after_done", 32'(done), 0);
          chk("busy_after_done", 32'(busy), 0);
          m_act = 1'b0;
        end
        m_age++;
      end else begin
        chk("idle_done", 32'(done), 0);
        chk("idle_grant", 32'(grant), 0);
        chk("idle_mul_start", 32'(mul_start), 0);
        chk("idle_result_held", 32'(result), 32'(m_held));
      end
    end
    p_req = req; p_x = x_in; p_y = y_in; p_grant = grant;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
    x_in[8*i +: 8] = x;
    y_in[8*i +: 8] = y;
  endtask

  task automatic wait_done(input string name);
    int n0;
    bit ok;
    n0 = log_owner.size();
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      if (log_owner.size() > n0) ok = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(ok), 1);
  endtask

  task automatic single(input int i, input logic [7:0] x, input logic [7:0] y,
                        input int exp_res, input int exp_err, input string name);
    int n0;
    n0 = log_owner.size();
    set_op(i, x, y);
    req[i] = 1'b1;
    wait_done(name);
    req[i] = 1'b0;
    if (log_owner.size() > n0) begin
      chk({name, "_owner"}, 32'(log_owner[n0]), 32'(i));
      chk({name, "_res"}, 32'(log_res[n0]), 32'(exp_res));
      chk({name, "_err"}, 32'(log_err[n0]), 32'(exp_err));
    end
    tick(); tick();
  endtask

  task automatic rst_vals(input string name);
    chk({name, "_grant"}, 32'(grant), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_result"}, 32'(result), 0);
    chk({name, "_err"}, 32'(err), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_mul_reset"}, 32'(mul_reset), 1);
    chk({name, "_mul_start"}, 32'(mul_start), 0);
    chk({name, "_mul_x"}, 32'(mul_x), 0);
    chk({name, "_mul_y"}, 32'(mul_y), 0);
  endtask

  initial begin
    int n0;
    bit seen;
    reset = 1'b1; req = '0; x_in = '0; y_in = '0;
    #12 rst_vals("reset");
    @(posedge clock); #3 reset = 1'b0;
    tick(); tick();

    // single job, then back-to-back on requester 1 (CLR must clear accumulator)
    single(0, 8'd13, 8'd11, 143, 0, "single");
    single(1, 8'd13, 8'd11, 143, 0, "b2b_a");
    single(1, 8'd7,  8'd9,  63,  0, "b2b_b");

    // corners on requester 3 (leaves pointer at 3 for the rotation test)
    single(3, 8'd255, 8'd255, 65025, 0, "c_ffxff");
    single(3, 8'd0,   8'd200, 0,     0, "c_0x200");
    single(3, 8'd200, 8'd0,   0,     0, "c_200x0");
    single(3, 8'd1,   8'd255, 255,   0, "c_1x255");
    single(3, 8'd128, 8'd2,   256,   0, "c_128x2");

    // round robin with everyone requesting
    n0 = log_owner.size();
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'd10);
    req = 4'hF;
    for (int j = 0; j < 5; j++) wait_done("rr");
    req = '0;
    if (log_owner.size() >= n0 + 5) begin
      chk("rr_o0", 32'(log_owner[n0]), 0);   chk("rr_r0", 32'(log_res[n0]), 10);
      chk("rr_o1", 32'(log_owner[n0+1]), 1); chk("rr_r1", 32'(log_res[n0+1]), 20);
      chk("rr_o2", 32'(log_owner[n0+2]), 2); chk("rr_r2", 32'(log_res[n0+2]), 30);
      chk("rr_o3", 32'(log_owner[n0+3]), 3); chk("rr_r3", 32'(log_res[n0+3]), 40);
      chk("rr_o4", 32'(log_owner[n0+4]), 0); chk("rr_r4", 32'(log_res[n0+4]), 10);
    end
    tick(); tick();

    // late requester 2 arriving during job 0 is served after 1
    single(3, 8'd3, 8'd3, 9, 0, "pre_late");
    n0 = log_owner.size();
    set_op(0, 8'd2, 8'd3); set_op(1, 8'd4, 8'd5); set_op(2, 8'd6, 8'd7);
    req = 4'b0011;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant == 4'b0001) seen = 1'b1;
    end
    chk("late_grant0_seen", 32'(seen), 1);
    req[2] = 1'b1;
    for (int j = 0; j < 3; j++) wait_done("late");
    req = '0;
    if (log_owner.size() >= n0 + 3) begin
      chk("late_o0", 32'(log_owner[n0]), 0);   chk("late_r0", 32'(log_res[n0]), 6);
      chk("late_o1", 32'(log_owner[n0+1]), 1); chk("late_r1", 32'(log_res[n0+1]), 20);
      chk("late_o2", 32'(log_owner[n0+2]), 2); chk("late_r2", 32'(log_res[n0+2]), 42);
    end
    tick(); tick();

    // timeout with a stalled multiplier, then a normal job
    stall = 1'b1;
    single(1, 8'd5, 8'd6, 0, 1, "timeout");
    stall = 1'b0;
    single(2, 8'd9, 8'd9, 81, 0, "after_to");

    // reset in the middle of WAIT
    set_op(2, 8'd10, 8'd10);
    req[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (grant == 4'b0100) seen = 1'b1;
    end
    chk("abort_grant_seen", 32'(seen), 1);
    tick(); tick(); tick();
    @(posedge clock); #3 reset = 1'b1; req = '0;
    #1 rst_vals("mid_reset");
    @(posedge clock); #3 reset = 1'b0;
    n0 = log_owner.size();
    for (int c = 0; c < 12; c++) tick();
    chk("abort_no_done", 32'(log_owner.size()), 32'(n0));
    set_op(0, 8'd11, 8'd11); set_op(3, 8'd12, 8'd12);
    req = 4'b1001;
    wait_done("post_rst_a");
    req[0] = 1'b0;
    wait_done("post_rst_b");
    req = '0;
    if (log_owner.size() >= n0 + 2) begin
      chk("post_rst_o0", 32'(log_owner[n0]), 0);   chk("post_rst_r0", 32'(log_res[n0]), 121);
      chk("post_rst_o1", 32'(log_owner[n0+1]), 3); chk("post_rst_r1", 32'(log_res[n0+1]), 144);
    end
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
